dm_cache_ctrl: RTL and testbench

//   Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store

---
 rtl/cache_pkg.sv | 31 +++
 rtl/dm_cache_array.sv | 56 +++++
 rtl/dm_cache_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMP     = 3'd1,
        RF_REQ  = 3'd2,
        RF_WAIT = 3'd3,
        WT_REQ  = 3'd4,
        WT_WAIT = 3'd5,
        DONE    = 3'd6
    } state_t;

    function automatic int calc_off_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int calc_wrd_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int addr_width, input int data_width,
                                      input int num_lines, input int line_words);
        return addr_width - calc_off_w(data_width) - calc_idx_w(num_lines) - calc_wrd_w(line_words);
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage: async-cleared valid bits, synchronous writes, combinational read.
module dm_cache_array
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 22
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [calc_idx_w(NUM_LINES)-1:0]  idx,
    input  logic [calc_wrd_w(LINE_WORDS)-1:0] word,
    input  logic                          data_we,
    input  logic [calc_wrd_w(LINE_WORDS)-1:0] wr_word,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          tag_we,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic                          inv,
    output logic                          line_valid,
    output logic [TAG_W-1:0]              line_tag,
    output logic [DATA_WIDTH-1:0]         line_data
);

    logic [NUM_LINES-1:0]  valid_r;
    logic [TAG_W-1:0]      tag_r  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_r [NUM_LINES][LINE_WORDS];

    // Valid bits: a line becomes valid only when its tag is committed after the last refill word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (tag_we) begin
            valid_r[idx] <= 1'b1;
        end else if (inv) begin
            valid_r[idx] <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_r[idx] <= wr_tag;
        end
        if (data_we) begin
            data_r[idx][wr_word] <= wr_data;
        end
    end

    assign line_valid = valid_r[idx];
    assign line_tag   = tag_r[idx];
    assign line_data  = data_r[idx][word];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int OFF_W = calc_off_w(DATA_WIDTH);
    localparam int WRD_W = calc_wrd_w(LINE_WORDS);
    localparam int IDX_W = calc_idx_w(NUM_LINES);
    localparam int TAG_W = calc_tag_w(ADDR_WIDTH, DATA_WIDTH, NUM_LINES, LINE_WORDS);
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(LINE_WORDS - 1);

    state_t                state_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [WRD_W-1:0]      cnt_r;

    logic [TAG_W-1:0]      tag_s;
    logic [IDX_W-1:0]      idx_s;
    logic [WRD_W-1:0]      word_s;
    logic [WRD_W-1:0]      cnt_nxt_s;
    logic                  line_valid_s;
    logic [TAG_W-1:0]      line_tag_s;
    logic [DATA_WIDTH-1:0] line_data_s;
    logic                  hit_s;
    logic                  data_we_s;
    logic [WRD_W-1:0]      wr_word_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  tag_we_s;
    logic                  inv_s;

    assign tag_s     = addr_r[ADDR_WIDTH-1 -: TAG_W];
    assign idx_s     = addr_r[OFF_W+WRD_W +: IDX_W];
    assign word_s    = addr_r[OFF_W +: WRD_W];
    assign cnt_nxt_s = cnt_r + 1'b1;
    assign hit_s     = line_valid_s && (line_tag_s == tag_s);

    dm_cache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx_s),
        .word       (word_s),
        .data_we    (data_we_s),
        .wr_word    (wr_word_s),
        .wr_data    (wr_data_s),
        .tag_we     (tag_we_s),
        .wr_tag     (tag_s),
        .inv        (inv_s),
        .line_valid (line_valid_s),
        .line_tag   (line_tag_s),
        .line_data  (line_data_s)
    );

    // Array write controls: store hits update in CMP, refill words land in RF_WAIT.
    always_comb begin
        data_we_s = 1'b0;
        wr_word_s = word_s;
        wr_data_s = wdata_r;
        tag_we_s  = 1'b0;
        inv_s     = 1'b0;
        case (state_r)
            CMP: begin
                if (we_r) begin
                    data_we_s = hit_s;
                end else begin
                    inv_s = !hit_s;
                end
            end
            RF_WAIT: begin
                wr_word_s = cnt_r;
                wr_data_s = mem_rdata;
                data_we_s = mem_ready;
                tag_we_s  = mem_ready && (cnt_r == LAST_WORD);
            end
            default: begin
                data_we_s = 1'b0;
            end
        endcase
    end

    // Control FSM; all CPU and memory outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            cnt_r     <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_req) begin
                        we_r    <= cpu_we;
                        addr_r  <= cpu_addr;
                        wdata_r <= cpu_wdata;
                        state_r <= CMP;
                    end
                end
                CMP: begin
                    if (we_r) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_r;
                        mem_wdata <= wdata_r;
                        state_r   <= WT_REQ;
                    end else if (hit_s) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= line_data_s;
                        state_r   <= DONE;
                    end else begin
                        cnt_r    <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {tag_s, idx_s, {WRD_W{1'b0}}, {OFF_W{1'b0}}};
                        state_r  <= RF_REQ;
                    end
                end
                RF_REQ: begin
                    mem_req <= 1'b0;
                    state_r <= RF_WAIT;
                end
                RF_WAIT: begin
                    if (mem_ready) begin
                        if (cnt_r == LAST_WORD) begin
                            state_r <= CMP;
                        end else begin
                            cnt_r    <= cnt_nxt_s;
                            mem_req  <= 1'b1;
                            mem_addr <= {tag_s, idx_s, cnt_nxt_s, {OFF_W{1'b0}}};
                            state_r  <= RF_REQ;
                        end
                    end
                end
                WT_REQ: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state_r <= WT_WAIT;
                end
                WT_WAIT: begin
                    if (mem_ready) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= '0;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    cpu_rdata <= '0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic first_r;

    // Classify each request once, on its first CMP visit; the post-refill CMP is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_r  <= 1'b0;
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            first_r <= (state_r == IDLE) && cpu_req;
            if ((state_r == CMP) && first_r) begin
                if (hit_s) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a single-cycle word memory model.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] wmem [logic [31:0]];
    logic [31:0] rd_q [$];
    int          wr_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;
    logic        req_prev = 1'b0;
    logic        b2b_seen = 1'b0;

    dm_cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: answers one cycle after each request; unwritten words read as A ^ A5A5_0000.
    always @(posedge clk) begin
        mem_ready <= mem_req;
        if (mem_req && req_prev) b2b_seen = 1'b1;
        req_prev = mem_req;
        if (mem_req) begin
            if (mem_we) begin
                wmem[mem_addr] = mem_wdata;
                wr_cnt++;
                last_wa = mem_addr;
                last_wd = mem_wdata;
            end else begin
                rd_q.push_back(mem_addr);
                mem_rdata <= wmem.exists(mem_addr) ? wmem[mem_addr] : (mem_addr ^ 32'hA5A5_0000);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU transaction; lat counts edges from the request sample edge to the edge that sees cpu_ready.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output int lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        lat = -1;
        rdata = 32'd0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (cpu_ready) begin
                lat = k + 1;
                rdata = cpu_rdata;
                break;
            end
            @(posedge clk);
        end
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check("ready_pulse", {31'd0, cpu_ready}, 32'd0);
    endtask

    task automatic run(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_data, input int exp_rd, input int exp_wr);
        int          rd0, wr0, lat;
        logic [31:0] rdata;
        rd0 = rd_q.size();
        wr0 = wr_cnt;
        access(we, addr, wd, rdata, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, rdata, exp_data);
        check({tag, "_rds"}, rd_q.size() - rd0, exp_rd);
        check({tag, "_wrs"}, wr_cnt - wr0, exp_wr);
    endtask

    initial begin
        int b;
        rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_mreq", {31'd0, mem_req}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: cold read refills the line in address order
        b = rd_q.size();
        run("cold_rd", 1'b0, 32'h40, 32'd0, 11, 32'hA5A5_0040, 4, 0);
        for (int i = 0; i < 4; i++) check("refill_addr", rd_q[b + i], 32'h40 + 32'(4 * i));
        // 2: read hit in the same line
        run("hit_rd", 1'b0, 32'h48, 32'd0, 2, 32'hA5A5_0048, 0, 0);
`ifdef CACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'd1);
        check("miss_cnt", miss_cnt, 32'd1);
`endif
        // 3: store hit is written through and updates the line
        run("wr_hit", 1'b1, 32'h44, 32'hDEAD_BEEF, 4, 32'd0, 0, 1);
        check("wt_addr", last_wa, 32'h44);
        check("wt_data", last_wd, 32'hDEAD_BEEF);
        run("rd_after_wr", 1'b0, 32'h44, 32'd0, 2, 32'hDEAD_BEEF, 0, 0);
        // 4: store miss does not allocate
        run("wr_miss", 1'b1, 32'h1000, 32'h1234, 4, 32'd0, 0, 1);
        run("rd_1000", 1'b0, 32'h1000, 32'd0, 11, 32'h1234, 4, 0);
        // 5: conflicting tag evicts the line
        run("evict", 1'b0, 32'h440, 32'd0, 11, 32'hA5A5_0440, 4, 0);
        run("reread_40", 1'b0, 32'h40, 32'd0, 11, 32'hA5A5_0040, 4, 0);

        // 6: reset while waiting for a refill word
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        repeat (3) @(posedge clk);
        #1;
        check("mid_maddr", mem_addr, 32'h80);
        #2;
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("mid_rst_maddr", mem_addr, 32'd0);
        check("mid_rst_mreq", {31'd0, mem_req}, 32'd0);
        check("mid_rst_mwdata", mem_wdata, 32'd0);
        check("mid_rst_ready", {31'd0, cpu_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run("post_rst_40", 1'b0, 32'h40, 32'd0, 11, 32'hA5A5_0040, 4, 0);
        run("post_rst_80", 1'b0, 32'h80, 32'd0, 11, 32'hA5A5_0080, 4, 0);
`ifdef CACHE_STATS_EN
        check("post_rst_hits", hit_cnt, 32'd0);
        check("post_rst_miss", miss_cnt, 32'd2);
`endif
        check("mem_req_b2b", {31'd0, b2b_seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
